// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit ALU between two valid/ready requesters.
// The result is held in a response register until its owner consumes it.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [2:0]         req0_op,
    input  logic [WIDTH-1:0]   req0_src1,
    input  logic [WIDTH-1:0]   req0_src2,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [2:0]         req1_op,
    input  logic [WIDTH-1:0]   req1_src1,
    input  logic [WIDTH-1:0]   req1_src2,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_zero,
    output logic               rsp_carry,
    output logic [COUNT_W-1:0] ops_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_last_grant;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic [COUNT_W-1:0] r_count;

    logic               w_grant0;
    logic               w_grant1;
    logic [2:0]         w_op;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_alu_carry;
    logic               w_consume;

    // Under contention the requester that did not win last time is granted.
    assign w_grant0 = (r_state == IDLE) && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = (r_state == IDLE) && req1_valid && (!req0_valid || !r_last_grant);

    assign w_op  = w_grant1 ? req1_op   : req0_op;
    assign w_a   = w_grant1 ? req1_src1 : req0_src1;
    assign w_b   = w_grant1 ? req1_src2 : req0_src2;
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement leaves a value unassigned (no latch).
    always_comb begin
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        unique case (w_op)
            3'b000:  w_alu_result = w_a & w_b;
            3'b001:  w_alu_result = w_a | w_b;
            3'b010: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
            end
            3'b110:  w_alu_result = w_a - w_b;
            3'b111:  w_alu_result = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
            default: w_alu_result = '0;
        endcase
    end

    assign w_consume = (r_rsp0_valid && rsp0_ready) || (r_rsp1_valid && rsp1_ready);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_carry      <= 1'b0;
            r_count      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_result     <= w_alu_result;
                        r_zero       <= (w_alu_result == '0);
                        r_carry      <= w_alu_carry;
                        r_rsp0_valid <= w_grant0;
                        r_rsp1_valid <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (w_consume) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_count      <= r_count + 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_carry  = r_carry;
    assign ops_count  = r_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU ops, round-robin order, backpressure,
// reset during a pending response and counter wrap (COUNT_W = 2).
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int WIDTH   = 32;
    localparam int COUNT_W = 2;

    logic               clk = 1'b0;
    logic               resetn;
    logic               req0_valid, req0_ready;
    logic [2:0]         req0_op;
    logic [WIDTH-1:0]   req0_src1, req0_src2;
    logic               req1_valid, req1_ready;
    logic [2:0]         req1_op;
    logic [WIDTH-1:0]   req1_src1, req1_src2;
    logic               rsp0_valid, rsp0_ready;
    logic               rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_zero, rsp_carry;
    logic [COUNT_W-1:0] ops_count;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_src1  (req0_src1),
        .req0_src2  (req0_src2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_src1  (req1_src1),
        .req1_src2  (req1_src2),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry),
        .ops_count  (ops_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v0, input logic v1,
                             input logic [31:0] res, input logic z, input logic c);
        check({tag, ".rsp0_valid"}, 32'(rsp0_valid), 32'(v0));
        check({tag, ".rsp1_valid"}, 32'(rsp1_valid), 32'(v1));
        check({tag, ".result"},     rsp_result,      res);
        check({tag, ".zero"},       32'(rsp_zero),   32'(z));
        check({tag, ".carry"},      32'(rsp_carry),  32'(c));
    endtask

    // Single-cycle request on requester 0, followed by a check of the response.
    task automatic issue0(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic z,
                          input logic c);
        req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b;
        #1;
        check({tag, ".req0_ready"}, 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req0_op = 3'b000; req0_src1 = '0; req0_src2 = '0;
        check_rsp(tag, 1'b1, 1'b0, res, z, c);
    endtask

    task automatic consume0();
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_src1 = '0; req0_src2 = '0;
        req1_valid = 1'b0; req1_op = '0; req1_src1 = '0; req1_src2 = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        tick();
        check_rsp("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("reset.count", 32'(ops_count), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Add with wrap-around carry.
        issue0("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b1);
        check("add_wrap.count_held", 32'(ops_count), 32'd0);
        consume0();
        check("add_wrap.rsp0_clear", 32'(rsp0_valid), 32'd0);
        check("add_wrap.count", 32'(ops_count), 32'd1);

        // Reset while a response is pending discards it.
        issue0("or_pend", 3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        check_rsp("mid_reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("mid_reset.count", 32'(ops_count), 32'd0);

        // Continuous contention after reset: 0, 1, 0, 1 with consumers always ready.
        req0_valid = 1'b1; req0_op = 3'b010; req0_src1 = 32'd1;  req0_src2 = 32'd2;
        req1_valid = 1'b1; req1_op = 3'b000; req1_src1 = 32'hC; req1_src2 = 32'hA;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();
        resetn = 1'b1;
        #1;
        check("cont.first_ready0", 32'(req0_ready), 32'd1);
        check("cont.first_ready1", 32'(req1_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            logic owner;
            owner = i[0];
            tick();
            check_rsp($sformatf("cont%0d", i), !owner, owner,
                      owner ? 32'h8 : 32'h3, 1'b0, 1'b0);
            check($sformatf("cont%0d.no_ready0", i), 32'(req0_ready), 32'd0);
            check($sformatf("cont%0d.no_ready1", i), 32'(req1_ready), 32'd0);
            tick();
            check($sformatf("cont%0d.count", i), 32'(ops_count), 32'((i + 1) % 4));
            check($sformatf("cont%0d.next0", i), 32'(req0_ready), 32'(owner));
            check($sformatf("cont%0d.next1", i), 32'(req1_ready), 32'(!owner));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Backpressure on requester 1; requester 0 waits, its rsp_ready is ignored.
        req1_valid = 1'b1; req1_op = 3'b110; req1_src1 = 32'd10; req1_src2 = 32'd3;
        #1;
        check("bp.req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0; req1_src1 = 32'hDEAD; req1_src2 = 32'hBEEF;
        req0_valid = 1'b1; req0_op = 3'b001; req0_src1 = 32'h55;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_rsp($sformatf("bp%0d", i), 1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
            check($sformatf("bp%0d.req0_ready", i), 32'(req0_ready), 32'd0);
            check($sformatf("bp%0d.count", i), 32'(ops_count), 32'd0);
            tick();
        end
        req0_valid = 1'b0; rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        check("bp.rsp1_clear", 32'(rsp1_valid), 32'd0);
        check("wrap5.count", 32'(ops_count), 32'd1);

        // No valid: no grant, response registers hold in IDLE.
        tick();
        check_rsp("idle_hold", 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);
        check("idle_hold.count", 32'(ops_count), 32'd1);

        // SLT and unknown opcode.
        issue0("slt_true", 3'b111, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0);
        consume0();
        issue0("slt_uns", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        consume0();
        issue0("op011", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b0);
        consume0();
        check("ops.count_wrap", 32'(ops_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's 32-bit `alu` between two requesters, e.g. the execute stage and the branch/address unit.
- Requests use a valid/ready handshake and are granted round-robin.
- The ALU output is captured in a response register and held until the owning requester accepts it.
- Keeps a running count of completed operations for performance debug.

Parameters:
- WIDTH, 32: operand and result width. Must match the `alu` width.
- COUNT_W, 16: width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 presents an operation.
- req0_ready  output  1  arbiter accepts requester 0's operation this cycle.
- req0_op  input  3  ALU control code for requester 0.
- req0_src1  input  WIDTH  operand 1 for requester 0.
- req0_src2  input  WIDTH  operand 2 for requester 0.
- req1_valid, req1_ready, req1_op, req1_src1, req1_src2: same as the requester 0 ports, for requester 1.
- rsp0_valid  output  1  response register holds requester 0's result.
- rsp0_ready  input  1  requester 0 consumes the response.
- rsp1_valid  output  1  response register holds requester 1's result.
- rsp1_ready  input  1  requester 1 consumes the response.
- rsp_result  output  WIDTH  registered ALU result.
- rsp_zero  output  1  registered zero flag.
- rsp_carry  output  1  registered carry; meaningful for op 010 only, forced 0 otherwise.
- ops_count  output  COUNT_W  number of completed responses; wraps modulo 2^COUNT_W.

Behaviour:
- Op codes:
  - 000 AND
  - 001 OR
  - 010 ADD, carry = bit WIDTH of the (WIDTH+1)-bit sum
  - 110 SUB, carry 0
  - 111 SLT, unsigned compare, result 1 or 0
  - any other code: result 0, zero 1, carry 0
- Zero flag: zero = (result == 0) for every op.
- FSM has two states, IDLE and RESP.
- Reset (async, resetn = 0) drives:
  - state = IDLE
  - rsp0_valid = rsp1_valid = 0
  - rsp_result = 0, rsp_zero = 0, rsp_carry = 0
  - ops_count = 0
  - last_grant = 1, so requester 0 wins the first contention.
- IDLE:
  - Grant, combinational:
    - Only reqN_valid high: reqN_ready = 1.
    - Both high: grant the requester not equal to last_grant.
    - Never both readies high.
  - The ALU operand and op mux selects the granted requester.
  - On the handshake edge (reqN_valid & reqN_ready):
    - Capture result/zero/carry into the response registers.
    - Set rspN_valid = 1 and last_grant = N.
    - Go to RESP.
- RESP:
  - req0_ready = req1_ready = 0.
  - rspN_valid stays high.
  - rsp_result, rsp_zero and rsp_carry are held stable.
  - When rspN_ready = 1 (owner only): clear rspN_valid, increment ops_count, go to IDLE.
  - The non-owner's rsp_ready is ignored.
- Latency and throughput:
  - Response is valid one cycle after the accept edge.
  - Minimum issue interval is 2 cycles (accept, consume, accept). There is no accept in the same cycle as consume.
- Fairness: under continuous contention grants strictly alternate 0, 1, 0, 1, …
- A requester dropping valid before ready causes no grant and no state change.
- Requester inputs are don't-care outside the handshake cycle. Response registers do not change in IDLE.
- Reset mid-RESP discards the pending response. The counter is not incremented.
- ops_count wraps from 2^COUNT_W − 1 to 0 without a flag.

Test Plan:
1. Single add wrap: req0 op 010, src1 0xFFFFFFFF, src2 0x00000001.
   - Required response: next cycle rsp0_valid = 1, rsp_result = 0, rsp_zero = 1, rsp_carry = 1.
   - rsp0_ready = 1 → IDLE, ops_count = 1.
2. Contention after reset: req0 and req1 valid continuously, rsp ready held 1.
   - Required response: grant order 0, 1, 0, 1. Each rspN_valid asserted only for its owner, at 2-cycle spacing.
3. Backpressure: req1 op 110 with 10 − 3; hold rsp1_ready = 0 for 5 cycles.
   - Required response: rsp_result = 7 stable; req0_ready = 0 throughout even with req0_valid = 1.
   - Asserting rsp0_ready has no effect.
4. SLT and unknown ops:
   - op 111 with 3, 5 → required: result 1.
   - op 111 with 0xFFFFFFFF, 1 → required: result 0, zero = 1.
   - op 011 with any operands → required: result 0, zero = 1, carry = 0.
5. Reset mid-RESP: pull resetn low while rsp0_valid = 1.
   - Required response: all outputs go immediately to reset values; ops_count = 0.
   - First grant after release goes to requester 0.
6. Counter wrap: with COUNT_W = 2, complete 5 operations → required: ops_count = 1.
